// File: rtl/puf_response_checker.sv
// puf_response_checker
// Consumer end of the ring-oscillator PUF serial bit stream. Deserializes
// response bits into a RESP_WIDTH word. An enrollment stores that word as the
// reference key. An authentication compares the word against the key bit by
// bit, then reports the Hamming distance and a match/LED result.
//
// Optional build macro: PUF_MAJORITY_VOTE_EN
//   When defined, each response bit is the majority of 3 consecutive valid
//   samples, so COLLECT consumes 3*RESP_WIDTH valid samples.
//   When undefined, each valid sample is one response bit.
//   The port list is identical in both builds.
//
// Request / stream semantics:
//   enroll_req and auth_req are level requests. They are sampled only while the
//   block is in IDLE (busy=0), and enroll wins when both are high. Requests
//   seen while busy are dropped, not queued. puf_bit_in is consumed only in a
//   COLLECT cycle with puf_bit_valid=1; there is no back-pressure, so the
//   source must not present a valid bit unless it is willing to lose it outside
//   COLLECT. done is a single-cycle pulse marking completion, and the result
//   outputs (enrolled, match, hd_out) are valid from that cycle onward.
module puf_response_checker #(
    parameter int RESP_WIDTH = 32,
    parameter int HD_THRESH  = 4,
    parameter int HD_WIDTH   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                puf_bit_in,
    input  logic                puf_bit_valid,
    input  logic                enroll_req,
    input  logic                auth_req,
    output logic                busy,
    output logic                done,
    output logic                enrolled,
    output logic                match,
    output logic [HD_WIDTH-1:0] hd_out,
    output logic                led_on,
    output logic [1:0]          dbg_state
);

    localparam int CNT_W = $clog2(RESP_WIDTH) + 1;
    localparam int IDX_W = (RESP_WIDTH > 1) ? $clog2(RESP_WIDTH) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_COMPARE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic MODE_ENROLL = 1'b0;
    localparam logic MODE_AUTH   = 1'b1;

    logic [1:0]            r_state;
    logic                  r_mode;
    logic [RESP_WIDTH-1:0] r_shift;
    logic [RESP_WIDTH-1:0] r_key;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [IDX_W-1:0]      r_cmp_idx;
    logic [HD_WIDTH-1:0]   r_hd_acc;
    logic                  r_enrolled;
    logic                  r_match;
    logic [HD_WIDTH-1:0]   r_hd;

    logic [1:0]            w_state_next;
    logic                  w_accept;
    logic                  w_smp_in;
    logic                  w_bit_strobe;
    logic                  w_bit_val;
    logic                  w_last_bit;
    logic [RESP_WIDTH-1:0] w_shift_next;
    logic                  w_diff;
    logic                  w_cmp_last;
    logic [HD_WIDTH-1:0]   w_hd_next;

    // A request is taken only from IDLE; enroll has priority over auth.
    assign w_accept = (r_state == S_IDLE) && (enroll_req || auth_req);

    // A raw sample is consumed only while collecting.
    assign w_smp_in = (r_state == S_COLLECT) && puf_bit_valid;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] r_vote_cnt;
    logic [1:0] r_vote_smp;

    // Gather the first two samples of each triple; the third one resolves the vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vote_cnt <= 2'd0;
            r_vote_smp <= 2'd0;
        end else if (w_accept) begin
            r_vote_cnt <= 2'd0;
            r_vote_smp <= 2'd0;
        end else if (w_smp_in) begin
            if (r_vote_cnt == 2'd2) begin
                r_vote_cnt <= 2'd0;
            end else begin
                r_vote_cnt <= r_vote_cnt + 2'd1;
                r_vote_smp <= {r_vote_smp[0], puf_bit_in};
            end
        end
    end

    assign w_bit_strobe = w_smp_in && (r_vote_cnt == 2'd2);
    assign w_bit_val    = (r_vote_smp[1] & r_vote_smp[0]) |
                          (r_vote_smp[1] & puf_bit_in)    |
                          (r_vote_smp[0] & puf_bit_in);
`else
    assign w_bit_strobe = w_smp_in;
    assign w_bit_val    = puf_bit_in;
`endif

    // The oldest bit migrates toward the MSB, so the first bit ends in RESP_WIDTH-1.
    assign w_shift_next = {r_shift[RESP_WIDTH-2:0], w_bit_val};
    assign w_last_bit   = w_bit_strobe && (r_bit_cnt == CNT_W'(RESP_WIDTH - 1));

    // Bit-serial comparison, MSB first, folding the last difference into the result.
    assign w_diff     = r_key[r_cmp_idx] ^ r_shift[r_cmp_idx];
    assign w_cmp_last = (r_cmp_idx == '0);
    assign w_hd_next  = r_hd_acc + {{(HD_WIDTH-1){1'b0}}, w_diff};

    // Next-state decode for the request/collect/compare/done sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_last_bit) begin
                    if (r_mode == MODE_AUTH && r_enrolled) begin
                        w_state_next = S_COMPARE;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_COMPARE: begin
                if (w_cmp_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the request mode and deserialize the incoming response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= MODE_ENROLL;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_mode    <= enroll_req ? MODE_ENROLL : MODE_AUTH;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_bit_strobe) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    // Store the reference key at the end of an enrollment; a re-enrollment overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key      <= '0;
            r_enrolled <= 1'b0;
        end else if (w_last_bit && r_mode == MODE_ENROLL) begin
            r_key      <= w_shift_next;
            r_enrolled <= 1'b1;
        end
    end

    // Walk the bit index down from the MSB and accumulate differences.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_idx <= '0;
            r_hd_acc  <= '0;
        end else if (r_state == S_COLLECT && w_last_bit) begin
            r_cmp_idx <= IDX_W'(RESP_WIDTH - 1);
            r_hd_acc  <= '0;
        end else if (r_state == S_COMPARE && !w_cmp_last) begin
            r_cmp_idx <= r_cmp_idx - IDX_W'(1);
            r_hd_acc  <= w_hd_next;
        end
    end

    // Result registers: cleared on acceptance, written at the end of a comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match <= 1'b0;
            r_hd    <= '0;
        end else if (w_accept) begin
            r_match <= 1'b0;
            r_hd    <= '0;
        end else if (r_state == S_COMPARE && w_cmp_last) begin
            r_match <= (w_hd_next <= HD_WIDTH'(HD_THRESH));
            r_hd    <= w_hd_next;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign enrolled  = r_enrolled;
    assign match     = r_match;
    assign hd_out    = r_hd;
    assign led_on    = r_match;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_puf_response_checker.sv
// Bench for puf_response_checker with RESP_WIDTH=8, HD_THRESH=1.
// Expected results come from a small reference model kept in the bench.
// Layout of each expected entry: [15:8]=latency, [7]=enrolled, [6]=match, [5:0]=hd.
module tb_puf_response_checker;

  localparam int RW  = 8;
  localparam int THR = 1;
  localparam int HDW = 6;
  localparam int W   = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           puf_bit_in = 1'b0;
  logic           puf_bit_valid = 1'b0;
  logic           enroll_req = 1'b0;
  logic           auth_req = 1'b0;
  logic           busy;
  logic           done;
  logic           enrolled;
  logic           match;
  logic [HDW-1:0] hd_out;
  logic           led_on;
  logic [1:0]     dbg_state;

  logic [W-1:0]   exp_q[$];
  logic [RW-1:0]  m_key = '0;
  logic           m_enrolled = 1'b0;
  int             n_checks = 0;
  int             n_pass = 0;

  puf_response_checker #(.RESP_WIDTH(RW), .HD_THRESH(THR), .HD_WIDTH(HDW)) dut (
    .clk(clk), .rst(rst), .puf_bit_in(puf_bit_in), .puf_bit_valid(puf_bit_valid),
    .enroll_req(enroll_req), .auth_req(auth_req), .busy(busy), .done(done),
    .enrolled(enrolled), .match(match), .hd_out(hd_out), .led_on(led_on),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m_key = '0;
    m_enrolled = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic b);
    repeat ($urandom_range(0, 2)) begin
      puf_bit_valid = 1'b0;
      puf_bit_in = 1'($urandom_range(0, 1));
      tick();
    end
    puf_bit_valid = 1'b1;
    puf_bit_in = b;
    tick();
    puf_bit_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
`ifdef PUF_MAJORITY_VOTE_EN
    int flip;
    flip = $urandom_range(0, 3);
    for (int k = 0; k < 3; k++) send_sample((k == flip) ? ~b : b);
`else
    send_sample(b);
`endif
  endtask

  // Model the expected outcome, push it, drive the request and wait for done.
  task automatic do_request(input logic en, input logic au, input logic [RW-1:0] word,
                            input logic noise, output int lat, output logic saw_cmp);
    logic [W-1:0] e;
    int hd;
    if (en) begin
      m_key = word;
      m_enrolled = 1'b1;
      e = {8'd1, 1'b1, 1'b0, 6'd0};
    end else if (m_enrolled) begin
      hd = $countones(m_key ^ word);
      e = {8'd9, 1'b1, (hd <= THR), 6'(hd)};
    end else begin
      e = {8'd1, 1'b0, 1'b0, 6'd0};
    end
    exp_q.push_back(e);
    enroll_req = en;
    auth_req = au;
    tick();
    enroll_req = noise;
    auth_req = noise;
    for (int i = RW - 1; i >= 0; i--) send_bit(word[i]);
    enroll_req = 1'b0;
    auth_req = 1'b0;
    saw_cmp = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (dbg_state == 2'd2) saw_cmp = 1'b1;
      tick();
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (enrolled !== 1'b0) $display("FAIL reset_enrolled: got %b want 0", enrolled); else n_pass++;
    n_checks++; if ({match, led_on} !== 2'b00) $display("FAIL reset_match_led: got %b want 00", {match, led_on}); else n_pass++;
    n_checks++; if (hd_out !== '0) $display("FAIL reset_hd: got %0d want 0", hd_out); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
  endtask

  task automatic test_enroll();
    int lat; logic saw; logic [W-1:0] e;
    do_request(1'b1, 1'b0, 8'hB2, 1'b0, lat, saw);
    e = exp_q.pop_front();
    n_checks++; if (lat !== int'(e[15:8])) $display("FAIL enroll_latency: got %0d want %0d", lat, e[15:8]); else n_pass++;
    n_checks++; if (enrolled !== e[7]) $display("FAIL enroll_enrolled: got %b want %b", enrolled, e[7]); else n_pass++;
    n_checks++; if (match !== e[6]) $display("FAIL enroll_match: got %b want %b", match, e[6]); else n_pass++;
    n_checks++; if (dut.r_key !== 8'hB2) $display("FAIL enroll_key: got %h want b2", dut.r_key); else n_pass++;
    tick();
    n_checks++; if ({done, busy} !== 2'b00) $display("FAIL enroll_done_pulse: got done,busy=%b want 00", {done, busy}); else n_pass++;
  endtask

  task automatic test_auth_match();
    int lat; logic saw; logic [W-1:0] e;
    do_request(1'b0, 1'b1, 8'hB2, 1'b0, lat, saw);
    e = exp_q.pop_front();
    n_checks++; if (lat !== int'(e[15:8])) $display("FAIL auth_latency: got %0d want %0d", lat, e[15:8]); else n_pass++;
    n_checks++; if (hd_out !== e[5:0]) $display("FAIL auth_hd: got %0d want %0d", hd_out, e[5:0]); else n_pass++;
    n_checks++; if ({match, led_on} !== {e[6], e[6]}) $display("FAIL auth_match_led: got %b want %b%b", {match, led_on}, e[6], e[6]); else n_pass++;
    tick();
    n_checks++; if ({done, busy} !== 2'b00) $display("FAIL auth_done_pulse: got done,busy=%b want 00", {done, busy}); else n_pass++;
    repeat (3) tick();
    n_checks++; if ({match, hd_out} !== {e[6], e[5:0]}) $display("FAIL auth_hold: got %b/%0d want %b/%0d", match, hd_out, e[6], e[5:0]); else n_pass++;
  endtask

  task automatic test_auth_mismatch();
    int lat; logic saw; logic [W-1:0] e;
    logic [RW-1:0] words [2];
    words[0] = 8'hB3;
    words[1] = 8'h4D;
    for (int k = 0; k < 2; k++) begin
      do_request(1'b0, 1'b1, words[k], 1'b0, lat, saw);
      e = exp_q.pop_front();
      n_checks++; if (lat !== int'(e[15:8])) $display("FAIL mis_latency%0d: got %0d want %0d", k, lat, e[15:8]); else n_pass++;
      n_checks++; if (hd_out !== e[5:0]) $display("FAIL mis_hd%0d: got %0d want %0d", k, hd_out, e[5:0]); else n_pass++;
      n_checks++; if ({match, led_on} !== {e[6], e[6]}) $display("FAIL mis_match%0d: got %b want %b%b", k, {match, led_on}, e[6], e[6]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_unenrolled_and_priority();
    int lat; logic saw; logic [W-1:0] e;
    apply_reset();
    do_request(1'b0, 1'b1, 8'hB2, 1'b0, lat, saw);
    e = exp_q.pop_front();
    n_checks++; if (lat !== int'(e[15:8])) $display("FAIL unenr_latency: got %0d want %0d", lat, e[15:8]); else n_pass++;
    n_checks++; if ({enrolled, match, hd_out} !== e[7:0]) $display("FAIL unenr_result: got %h want %h", {enrolled, match, hd_out}, e[7:0]); else n_pass++;
    n_checks++; if (saw !== 1'b0) $display("FAIL unenr_no_compare: got %b want 0", saw); else n_pass++;
    tick();
    // Both requests together: enrollment must be taken.
    do_request(1'b1, 1'b1, 8'h5A, 1'b0, lat, saw);
    e = exp_q.pop_front();
    n_checks++; if (lat !== int'(e[15:8])) $display("FAIL both_latency: got %0d want %0d", lat, e[15:8]); else n_pass++;
    n_checks++; if (enrolled !== e[7]) $display("FAIL both_enrolled: got %b want %b", enrolled, e[7]); else n_pass++;
    n_checks++; if (dut.r_key !== 8'h5A) $display("FAIL both_key: got %h want 5a", dut.r_key); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat; logic saw; logic [W-1:0] e;
    auth_req = 1'b1;
    tick();
    auth_req = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    apply_reset();
    n_checks++; if ({busy, done, enrolled, match, led_on} !== 5'b0) $display("FAIL mid_rst_flags: got %b want 00000", {busy, done, enrolled, match, led_on}); else n_pass++;
    n_checks++; if (hd_out !== '0) $display("FAIL mid_rst_hd: got %0d want 0", hd_out); else n_pass++;
    n_checks++; if (dut.r_key !== '0) $display("FAIL mid_rst_key: got %h want 00", dut.r_key); else n_pass++;
    do_request(1'b0, 1'b1, 8'h5A, 1'b0, lat, saw);
    e = exp_q.pop_front();
    n_checks++; if (lat !== int'(e[15:8])) $display("FAIL mid_rst_auth_lat: got %0d want %0d", lat, e[15:8]); else n_pass++;
    n_checks++; if ({enrolled, match, hd_out} !== e[7:0]) $display("FAIL mid_rst_auth: got %h want %h", {enrolled, match, hd_out}, e[7:0]); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat; logic saw; logic [W-1:0] e;
    logic en; logic noise; logic [RW-1:0] word;
    for (int it = 0; it < 10; it++) begin
      en = (it == 0) || ($urandom_range(0, 3) == 0);
      noise = ($urandom_range(0, 2) == 0);
      if (en) begin
        word = RW'($urandom());
      end else begin
        word = m_key;
        repeat ($urandom_range(0, 3)) word[$urandom_range(0, RW - 1)] ^= 1'b1;
      end
      do_request(en, ~en, word, noise, lat, saw);
      e = exp_q.pop_front();
      n_checks++; if (lat !== int'(e[15:8])) $display("FAIL b2b_latency%0d: got %0d want %0d", it, lat, e[15:8]); else n_pass++;
      n_checks++; if ({enrolled, match, hd_out} !== e[7:0]) $display("FAIL b2b_result%0d: got %h want %h", it, {enrolled, match, hd_out}, e[7:0]); else n_pass++;
      n_checks++; if (dut.r_key !== m_key) $display("FAIL b2b_key%0d: got %h want %h", it, dut.r_key, m_key); else n_pass++;
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_enroll();
    test_auth_match();
    test_auth_mismatch();
    test_unenrolled_and_priority();
    test_reset_mid();
    test_back_to_back();
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
